// File: rtl/axi_slave_wr_burst_ctrl.sv
// AXI4-style write slave: one AW burst at a time, FIXED/INCR/WRAP addressing,
// W beats streamed to a byte-addressed memory port, SLVERR on config/window/WLAST errors.
module axi_slave_wr_burst_ctrl #(
  parameter int              ADDR_WIDTH = 32,
  parameter int              DATA_WIDTH = 32,
  parameter int              LEN_WIDTH  = 8,
  parameter longint unsigned MEM_BASE   = 0,
  parameter longint unsigned MEM_BYTES  = 4096
) (
  input  logic                    clk,
  input  logic                    rst_n,
  output logic                    AWREADY,
  input  logic                    AWVALID,
  input  logic [ADDR_WIDTH-1:0]   AWADDR,
  input  logic [LEN_WIDTH-1:0]    AWLEN,
  input  logic [2:0]              AWSIZE,
  input  logic [1:0]              AWBURST,
  output logic                    WREADY,
  input  logic                    WVALID,
  input  logic [DATA_WIDTH-1:0]   WDATA,
  input  logic [DATA_WIDTH/8-1:0] WSTRB,
  input  logic                    WLAST,
  input  logic                    BREADY,
  output logic                    BVALID,
  output logic [1:0]              BRESP,
  output logic                    mem_wen,
  output logic [ADDR_WIDTH-1:0]   mem_waddr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_wstrb
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam logic [2:0] MAX_SIZE = 3'($clog2(STRB_WIDTH));
  // One extra bit so a window ending exactly at 2^ADDR_WIDTH is representable.
  localparam logic [ADDR_WIDTH:0] WIN_LO = (ADDR_WIDTH+1)'(MEM_BASE);
  localparam logic [ADDR_WIDTH:0] WIN_HI = (ADDR_WIDTH+1)'(MEM_BASE + MEM_BYTES);

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;

  state_t                state_reg, state_next;
  logic                  awready_reg, wready_reg, bvalid_reg;
  logic [1:0]            bresp_reg;
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic [ADDR_WIDTH-1:0] sz_reg, sz_next;
  logic [ADDR_WIDTH-1:0] size_mask_reg, size_mask_next;
  logic [ADDR_WIDTH-1:0] wrap_mask_reg, wrap_mask_next;
  logic [LEN_WIDTH-1:0]  len_reg, len_next;
  logic [1:0]            burst_reg, burst_next;
  logic [LEN_WIDTH:0]    beat_cnt_reg, beat_cnt_next;
  logic                  err_reg, err_next;

  logic                  aw_fire, beat_fire, beat_last, in_window;
  logic [ADDR_WIDTH-1:0] aw_sz, aw_size_mask, aw_wrap_mask, incr_addr;
  logic [2:0]            wrap_shift;
  logic                  cfg_err;

  assign aw_fire   = (state_reg == IDLE) && AWVALID && awready_reg;
  assign beat_fire = (state_reg == DATA) && WVALID && wready_reg;
  assign beat_last = (beat_cnt_reg == {1'b0, len_reg});
  assign in_window = ({1'b0, addr_reg} >= WIN_LO) && ({1'b0, addr_reg} < WIN_HI);

  // Decode the incoming AW request: beat size, masks and configuration legality.
  always_comb begin
    aw_sz        = ADDR_WIDTH'(1) << AWSIZE;
    aw_size_mask = aw_sz - ADDR_WIDTH'(1);
    wrap_shift   = 3'd0;
    case (AWLEN)
      LEN_WIDTH'(1):  wrap_shift = 3'd1;
      LEN_WIDTH'(3):  wrap_shift = 3'd2;
      LEN_WIDTH'(7):  wrap_shift = 3'd3;
      LEN_WIDTH'(15): wrap_shift = 3'd4;
      default:        wrap_shift = 3'd0;
    endcase
    aw_wrap_mask = (aw_sz << wrap_shift) - ADDR_WIDTH'(1);
    cfg_err      = (AWSIZE > MAX_SIZE) || (AWBURST == BURST_RSVD) ||
                   ((AWBURST == BURST_WRAP) &&
                    ((wrap_shift == 3'd0) || ((AWADDR & aw_size_mask) != '0)));
  end

  // Unaligned INCR starts become aligned after the first beat.
  assign incr_addr = (addr_reg & ~size_mask_reg) + sz_reg;

  always_comb begin
    state_next     = state_reg;
    addr_next      = addr_reg;
    sz_next        = sz_reg;
    size_mask_next = size_mask_reg;
    wrap_mask_next = wrap_mask_reg;
    len_next       = len_reg;
    burst_next     = burst_reg;
    beat_cnt_next  = beat_cnt_reg;
    err_next       = err_reg;
    case (state_reg)
      IDLE: begin
        if (aw_fire) begin
          addr_next      = AWADDR;
          sz_next        = aw_sz;
          size_mask_next = aw_size_mask;
          wrap_mask_next = aw_wrap_mask;
          len_next       = AWLEN;
          burst_next     = AWBURST;
          beat_cnt_next  = '0;
          err_next       = cfg_err;
          state_next     = DATA;
        end
      end
      DATA: begin
        if (beat_fire) begin
          // The mismatching beat itself is still written; only later beats drop.
          err_next      = err_reg || !in_window || (WLAST != beat_last);
          beat_cnt_next = beat_cnt_reg + 1'b1;
          case (burst_reg)
            BURST_INCR:  addr_next = incr_addr;
            BURST_WRAP:  addr_next = (addr_reg & ~wrap_mask_reg) |
                                     ((addr_reg + sz_reg) & wrap_mask_reg);
            BURST_FIXED: addr_next = addr_reg;
            default:     addr_next = addr_reg;
          endcase
          if (beat_last) state_next = RESP;
        end
      end
      RESP: begin
        if (bvalid_reg && BREADY) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      awready_reg   <= 1'b0;
      wready_reg    <= 1'b0;
      bvalid_reg    <= 1'b0;
      bresp_reg     <= 2'b00;
      addr_reg      <= '0;
      sz_reg        <= '0;
      size_mask_reg <= '0;
      wrap_mask_reg <= '0;
      len_reg       <= '0;
      burst_reg     <= 2'b00;
      beat_cnt_reg  <= '0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      awready_reg   <= (state_next == IDLE);
      wready_reg    <= (state_next == DATA);
      bvalid_reg    <= (state_next == RESP);
      bresp_reg     <= ((state_next == RESP) && err_next) ? 2'b10 : 2'b00;
      addr_reg      <= addr_next;
      sz_reg        <= sz_next;
      size_mask_reg <= size_mask_next;
      wrap_mask_reg <= wrap_mask_next;
      len_reg       <= len_next;
      burst_reg     <= burst_next;
      beat_cnt_reg  <= beat_cnt_next;
      err_reg       <= err_next;
    end
  end

  assign AWREADY   = awready_reg;
  assign WREADY    = wready_reg;
  assign BVALID    = bvalid_reg;
  assign BRESP     = bresp_reg;
  assign mem_wen   = beat_fire && !err_reg && in_window;
  assign mem_waddr = addr_reg;
  assign mem_wdata = WDATA;
  assign mem_wstrb = WSTRB;

endmodule

// File: tb/tb_axi_slave_wr_burst_ctrl.sv
// Directed bench for axi_slave_wr_burst_ctrl: inputs change and outputs are
// checked on the falling edge, transactions complete on the rising edge.
module tb_axi_slave_wr_burst_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        AWREADY, AWVALID;
  logic [31:0] AWADDR;
  logic [7:0]  AWLEN;
  logic [2:0]  AWSIZE;
  logic [1:0]  AWBURST;
  logic        WREADY, WVALID;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WLAST;
  logic        BREADY, BVALID;
  logic [1:0]  BRESP;
  logic        mem_wen;
  logic [31:0] mem_waddr, mem_wdata;
  logic [3:0]  mem_wstrb;

  int checks   = 0;
  int failures = 0;

  axi_slave_wr_burst_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .AWREADY(AWREADY), .AWVALID(AWVALID), .AWADDR(AWADDR), .AWLEN(AWLEN),
    .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .WREADY(WREADY), .WVALID(WVALID), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST),
    .BREADY(BREADY), .BVALID(BVALID), .BRESP(BRESP),
    .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // AW handshake issued at a falling edge; returns at the falling edge after it.
  task automatic aw(input logic [31:0] addr, input logic [7:0] len,
                    input logic [2:0] size, input logic [1:0] burst);
    AWVALID = 1'b1; AWADDR = addr; AWLEN = len; AWSIZE = size; AWBURST = burst;
    #1 chk("aw_ready", AWREADY, 1'b1);
    @(posedge clk); @(negedge clk);
    AWVALID = 1'b0;
    #1 chk("aw_ready_low", AWREADY, 1'b0);
    chk("w_ready_up", WREADY, 1'b1);
    $display("AW addr=0x%0h len=%0d size=%0d burst=%0d", addr, len, size, burst);
  endtask

  task automatic beat(input logic [31:0] data, input logic [3:0] strb, input logic last,
                      input logic exp_wen, input logic [31:0] exp_addr);
    WVALID = 1'b1; WDATA = data; WSTRB = strb; WLAST = last;
    #1 chk("w_ready", WREADY, 1'b1);
    chk("mem_wen", mem_wen, exp_wen);
    chk("mem_waddr", mem_waddr, exp_addr);
    chk("mem_wdata", mem_wdata, data);
    chk("mem_wstrb", mem_wstrb, strb);
    $display("W data=0x%0h strb=0x%0h last=%0d -> wen=%0d addr=0x%0h",
             data, strb, last, mem_wen, mem_waddr);
    @(posedge clk); @(negedge clk);
    WVALID = 1'b0; WLAST = 1'b0;
  endtask

  task automatic resp(input logic [1:0] exp_resp);
    #1 chk("b_valid", BVALID, 1'b1);
    chk("b_resp", BRESP, exp_resp);
    chk("w_ready_down", WREADY, 1'b0);
    chk("aw_ready_in_resp", AWREADY, 1'b0);
    BREADY = 1'b1;
    @(posedge clk); @(negedge clk);
    BREADY = 1'b0;
    #1 chk("b_valid_low", BVALID, 1'b0);
    chk("aw_ready_back", AWREADY, 1'b1);
    $display("B resp=0x%0h", exp_resp);
  endtask

  initial begin
    rst_n = 1'b0; AWVALID = 1'b0; AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWBURST = '0;
    WVALID = 1'b0; WDATA = '0; WSTRB = '0; WLAST = 1'b0; BREADY = 1'b0;
    #1 chk("rst_awready", AWREADY, 1'b0);
    chk("rst_wready", WREADY, 1'b0);
    chk("rst_bvalid", BVALID, 1'b0);
    chk("rst_bresp", BRESP, 2'b00);
    chk("rst_mem_wen", mem_wen, 1'b0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1 chk("awready_before_edge", AWREADY, 1'b0);
    @(negedge clk);
    #1 chk("awready_after_release", AWREADY, 1'b1);

    // INCR, aligned
    aw(32'h100, 8'd3, 3'd2, 2'b01);
    beat(32'hA0, 4'hF, 1'b0, 1'b1, 32'h100);
    beat(32'hA1, 4'hF, 1'b0, 1'b1, 32'h104);
    beat(32'hA2, 4'hF, 1'b0, 1'b1, 32'h108);
    beat(32'hA3, 4'hF, 1'b1, 1'b1, 32'h10C);
    resp(2'b00);

    // W presented early must wait while IDLE, then WRAP burst
    WVALID = 1'b1; WDATA = 32'hEE; WSTRB = 4'hF;
    #1 chk("early_w_wready", WREADY, 1'b0);
    chk("early_w_wen", mem_wen, 1'b0);
    @(negedge clk);
    #1 chk("early_w_wready2", WREADY, 1'b0);
    WVALID = 1'b0;
    aw(32'h38, 8'd3, 3'd2, 2'b10);
    beat(32'hB0, 4'hF, 1'b0, 1'b1, 32'h38);
    beat(32'hB1, 4'hF, 1'b0, 1'b1, 32'h3C);
    beat(32'hB2, 4'hF, 1'b0, 1'b1, 32'h30);
    beat(32'hB3, 4'hF, 1'b1, 1'b1, 32'h34);
    resp(2'b00);

    // FIXED, byte beats
    aw(32'h20, 8'd2, 3'd0, 2'b00);
    beat(32'h11, 4'h1, 1'b0, 1'b1, 32'h20);
    beat(32'h22, 4'h1, 1'b0, 1'b1, 32'h20);
    beat(32'h33, 4'h1, 1'b1, 1'b1, 32'h20);
    resp(2'b00);

    // INCR running off the top of the window
    aw(32'hFF8, 8'd3, 3'd2, 2'b01);
    beat(32'hC0, 4'hF, 1'b0, 1'b1, 32'hFF8);
    beat(32'hC1, 4'hF, 1'b0, 1'b1, 32'hFFC);
    beat(32'hC2, 4'hF, 1'b0, 1'b0, 32'h1000);
    beat(32'hC3, 4'hF, 1'b1, 1'b0, 32'h1004);
    resp(2'b10);

    // Early WLAST on beat 1
    aw(32'h200, 8'd3, 3'd2, 2'b01);
    beat(32'hD0, 4'hF, 1'b0, 1'b1, 32'h200);
    beat(32'hD1, 4'hF, 1'b1, 1'b1, 32'h204);
    beat(32'hD2, 4'hF, 1'b0, 1'b0, 32'h208);
    beat(32'hD3, 4'hF, 1'b1, 1'b0, 32'h20C);
    resp(2'b10);

    // Missing WLAST on the final beat: final beat written, SLVERR
    aw(32'h300, 8'd1, 3'd2, 2'b01);
    beat(32'hF0, 4'hF, 1'b0, 1'b1, 32'h300);
    beat(32'hF1, 4'hF, 1'b0, 1'b1, 32'h304);
    resp(2'b10);

    // AWSIZE wider than the data bus
    aw(32'h0, 8'd1, 3'd3, 2'b01);
    beat(32'hE0, 4'hF, 1'b0, 1'b0, 32'h0);
    beat(32'hE1, 4'hF, 1'b1, 1'b0, 32'h8);
    resp(2'b10);

    // Reserved burst type
    aw(32'h40, 8'd0, 3'd2, 2'b11);
    beat(32'h77, 4'hF, 1'b1, 1'b0, 32'h40);
    resp(2'b10);

    // Single beat with BREADY held off for 5 cycles
    aw(32'h40, 8'd0, 3'd2, 2'b01);
    beat(32'h55, 4'h3, 1'b1, 1'b1, 32'h40);
    for (int i = 0; i < 5; i++) begin
      #1 chk("hold_bvalid", BVALID, 1'b1);
      chk("hold_bresp", BRESP, 2'b00);
      chk("hold_awready", AWREADY, 1'b0);
      @(negedge clk);
    end
    resp(2'b00);

    // Reset mid-DATA abandons the burst
    aw(32'h80, 8'd3, 3'd2, 2'b01);
    beat(32'h90, 4'hF, 1'b0, 1'b1, 32'h80);
    WVALID = 1'b1; WDATA = 32'h91; WSTRB = 4'hF;
    #2 rst_n = 1'b0;
    #1 chk("mid_rst_awready", AWREADY, 1'b0);
    chk("mid_rst_wready", WREADY, 1'b0);
    chk("mid_rst_bvalid", BVALID, 1'b0);
    chk("mid_rst_bresp", BRESP, 2'b00);
    chk("mid_rst_wen", mem_wen, 1'b0);
    chk("mid_rst_waddr", mem_waddr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("post_rst_awready0", AWREADY, 1'b0);
    @(negedge clk);
    #1 chk("post_rst_awready1", AWREADY, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk("post_rst_bvalid", BVALID, 1'b0);
      chk("post_rst_wen", mem_wen, 1'b0);
      chk("post_rst_wready", WREADY, 1'b0);
      @(negedge clk);
      #1;
    end
    WVALID = 1'b0;
    $display("RESET mid-burst handled");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
